gate_sweep_checker: RTL and testbench
=====================================

// Module: gate_sweep_checker
// PURPOSE
//  Self-test sequencer for the two-input logic gate block. It sits upstream and
//  downstream of that block. It drives a/b through all four input vectors, then
//  samples the six gate outputs after a settle delay. It assembles a 24-bit
//  truth table, compares each sample against an internal golden model, and
//  reports a mismatch count and a pass flag.
// PARAMETERS
//  SETTLE_CYCLES  1  cycles a vector is held before sampling; legal range >=1
//  PASSES         1  full 4-vector sweeps per start; legal range >=1
//  CNT_W          8  width of mismatch_cnt; the counter saturates at 2^CNT_W-1
// PORTS
//  clk           in   1      rising-edge clock
//  rst           in   1      synchronous, active-high reset
//  start         in   1      pulse; sampled only in IDLE
//  a_out         out  1      gate input a (drives the gate block)
//  b_out         out  1      gate input b
//  g_and         in   1      gate block AND output
//  g_or          in   1      gate block OR output
//  g_nand        in   1      gate block NAND output
//  g_nor         in   1      gate block NOR output
//  g_xor         in   1      gate block XOR output
//  g_xnor        in   1      gate block XNOR output
//  busy          out  1      high from the cycle after start until done
//  done          out  1      one-cycle pulse at the end of the run
//  truth_table   out  24     slice [6v+5:6v] = {xnor,xor,nor,nand,or,and} for v={a,b}
//  mismatch_cnt  out  CNT_W  total bit mismatches over all passes
//  pass          out  1      1 when the last run had zero mismatches; held until next start
// BEHAVIOUR
//  - Reset (any state, including mid-run): state=IDLE. All outputs are 0:
//    a_out, b_out, busy, done, truth_table, mismatch_cnt, pass.
//  - FSM states: IDLE, SETTLE, SAMPLE, DONE. All outputs are registered.
//  - IDLE, start=1 at an edge: the next cycle has busy=1, {a_out,b_out}=00,
//    mismatch_cnt=0, truth_table=0, pass=0, pass index=0, state=SETTLE.
//  - SETTLE: the vector is held for SETTLE_CYCLES cycles, then state=SAMPLE.
//  - SAMPLE (1 cycle): at the end of the cycle, g_* are captured into the slice for v.
//    - mismatch_cnt += popcount(captured ^ golden(v)), saturating at 2^CNT_W-1.
//    - If v==3 and the pass index is PASSES-1, next state=DONE.
//    - Else v increments mod 4 (the pass index increments on wrap), a_out/b_out update, and state=SETTLE.
//  - Golden slices (hex, 6-bit): v0=2C, v1=16, v2=16, v3=23; full table=24'h8D65AC.
//  - DONE (1 cycle): done=1, busy=0, a_out/b_out=0. pass=(mismatch_cnt==0), then state=IDLE.
//  - Latency: done is high in the cycle after edge N=4*PASSES*(SETTLE_CYCLES+1)+1.
//    Edges are counted after the edge that samples start.
//  - truth_table holds the most recent pass. It is rewritten per slice and is stable after done.
//  - start while busy or in DONE: ignored. There is no queueing.
//  - start and rst high together: rst wins.
// TESTING
//  - Ideal gate model, defaults, start pulse: truth_table=24'h8D65AC, mismatch_cnt=0, pass=1.
//    done is high exactly one cycle.
//  - g_and stuck at 0, PASSES=1: truth_table=24'h8965AC (bit 18 clear), mismatch_cnt=1, pass=0.
//  - g_xor inverted, PASSES=3: mismatch_cnt=12, pass=0.
//  - All g_* stuck at 0, CNT_W=2: mismatch_cnt saturates at 3, pass=0, truth_table=0.
//  - SETTLE_CYCLES=2, PASSES=1: done high in the cycle after the 13th edge following start.
//    {a_out,b_out} steps 00,01,10,11, each held 3 cycles. Repeated start while busy does not restart.
//  - rst asserted mid-SETTLE of v2: next cycle all outputs are 0 and state=IDLE.
//    A new start then gives a full correct run.

Source files
------------

// File: rtl/gate_sweep_checker_if.sv
// Stimulus/response bundle between the gate sweep checker and the gate block under test.
// The master side is the environment (start, gate outputs); the slave side is the checker.
interface gate_sweep_checker_if #(
   parameter int CNT_W = 8
);
   logic             start;
   logic             a_out;
   logic             b_out;
   logic             g_and;
   logic             g_or;
   logic             g_nand;
   logic             g_nor;
   logic             g_xor;
   logic             g_xnor;
   logic             busy;
   logic             done;
   logic [23:0]      truth_table;
   logic [CNT_W-1:0] mismatch_cnt;
   logic             pass;

   modport master (
      output start, g_and, g_or, g_nand, g_nor, g_xor, g_xnor,
      input  a_out, b_out, busy, done, truth_table, mismatch_cnt, pass
   );

   modport slave (
      input  start, g_and, g_or, g_nand, g_nor, g_xor, g_xnor,
      output a_out, b_out, busy, done, truth_table, mismatch_cnt, pass
   );
endinterface

// File: rtl/gate_sweep_checker.sv
// Self-test sequencer: sweeps a/b through all four vectors, captures the six gate
// outputs per vector into a truth table and counts bit mismatches against a golden model.
module gate_sweep_checker #(
   parameter int SETTLE_CYCLES = 1,
   parameter int PASSES        = 1,
   parameter int CNT_W         = 8
) (
   input logic                clk,
   input logic                rst,
   gate_sweep_checker_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      DONE
   } state_t;

   localparam int               SUM_W   = ((CNT_W > 3) ? CNT_W : 3) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state;
   logic [1:0]       vec;
   logic [31:0]      settle_cnt;
   logic [31:0]      pass_idx;
   logic             busy;
   logic             done;
   logic [23:0]      truth_table;
   logic [CNT_W-1:0] mismatch_cnt;
   logic             pass;

   logic [5:0]       captured;
   logic [5:0]       golden;
   logic [SUM_W-1:0] sum;
   logic [CNT_W-1:0] cnt_next;

   function automatic logic [2:0] popcount6(input logic [5:0] x);
      logic [2:0] n;
      n = 3'd0;
      for (int i = 0; i < 6; i++) begin
         n = n + 3'(x[i]);
      end
      return n;
   endfunction

   // Slice layout is {xnor,xor,nor,nand,or,and} with a = vec[1], b = vec[0].
   always_comb begin
      captured = {bus.g_xnor, bus.g_xor, bus.g_nor, bus.g_nand, bus.g_or, bus.g_and};
      golden   = {~(vec[1] ^ vec[0]), vec[1] ^ vec[0], ~(vec[1] | vec[0]),
                  ~(vec[1] & vec[0]), vec[1] | vec[0], vec[1] & vec[0]};
      sum      = SUM_W'(mismatch_cnt) + SUM_W'(popcount6(captured ^ golden));
      cnt_next = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         vec          <= 2'd0;
         settle_cnt   <= 32'd0;
         pass_idx     <= 32'd0;
         busy         <= 1'b0;
         done         <= 1'b0;
         truth_table  <= 24'd0;
         mismatch_cnt <= '0;
         pass         <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  busy         <= 1'b1;
                  vec          <= 2'd0;
                  settle_cnt   <= 32'd0;
                  pass_idx     <= 32'd0;
                  truth_table  <= 24'd0;
                  mismatch_cnt <= '0;
                  pass         <= 1'b0;
                  state        <= SETTLE;
               end
            end
            SETTLE: begin
               if (settle_cnt == 32'(SETTLE_CYCLES - 1)) begin
                  settle_cnt <= 32'd0;
                  state      <= SAMPLE;
               end else begin
                  settle_cnt <= settle_cnt + 32'd1;
               end
            end
            SAMPLE: begin
               case (vec)
                  2'd0:    truth_table[5:0]   <= captured;
                  2'd1:    truth_table[11:6]  <= captured;
                  2'd2:    truth_table[17:12] <= captured;
                  default: truth_table[23:18] <= captured;
               endcase
               mismatch_cnt <= cnt_next;
               // Vector returns to 00 on the final sample so a/b are low during DONE.
               vec <= vec + 2'd1;
               if (vec == 2'd3 && pass_idx == 32'(PASSES - 1)) begin
                  state <= DONE;
               end else begin
                  if (vec == 2'd3) begin
                     pass_idx <= pass_idx + 32'd1;
                  end
                  state <= SETTLE;
               end
            end
            DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               pass  <= (mismatch_cnt == '0);
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.a_out        = vec[1];
   assign bus.b_out        = vec[0];
   assign bus.busy         = busy;
   assign bus.done         = done;
   assign bus.truth_table  = truth_table;
   assign bus.mismatch_cnt = mismatch_cnt;
   assign bus.pass         = pass;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench for gate_sweep_checker: four instances with different parameters,
// each fed by a behavioural gate block with a selectable fault.
module tb_gate_sweep_checker;

   logic clk;
   logic rst;
   int   errors;
   int   checks;
   int   mode_d;
   int   mode_p3;
   int   mode_w2;
   int   mode_s2;

   gate_sweep_checker_if #(.CNT_W(8)) ifd ();
   gate_sweep_checker_if #(.CNT_W(8)) ifp3 ();
   gate_sweep_checker_if #(.CNT_W(2)) ifw2 ();
   gate_sweep_checker_if #(.CNT_W(8)) ifs2 ();

   gate_sweep_checker #(.SETTLE_CYCLES(1), .PASSES(1), .CNT_W(8)) dut_d  (.clk(clk), .rst(rst), .bus(ifd));
   gate_sweep_checker #(.SETTLE_CYCLES(1), .PASSES(3), .CNT_W(8)) dut_p3 (.clk(clk), .rst(rst), .bus(ifp3));
   gate_sweep_checker #(.SETTLE_CYCLES(1), .PASSES(1), .CNT_W(2)) dut_w2 (.clk(clk), .rst(rst), .bus(ifw2));
   gate_sweep_checker #(.SETTLE_CYCLES(2), .PASSES(1), .CNT_W(8)) dut_s2 (.clk(clk), .rst(rst), .bus(ifs2));

   // Fault modes: 0 ideal, 1 AND stuck at 0, 2 XOR inverted, 3 all outputs stuck at 0.
   function automatic logic [5:0] gate_model(input logic a, input logic b, input int mode);
      logic [5:0] r;
      r = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b};
      if (mode == 1) r[0] = 1'b0;
      if (mode == 2) r[4] = ~r[4];
      if (mode == 3) r = 6'd0;
      return r;
   endfunction

   assign {ifd.g_xnor, ifd.g_xor, ifd.g_nor, ifd.g_nand, ifd.g_or, ifd.g_and}       = gate_model(ifd.a_out, ifd.b_out, mode_d);
   assign {ifp3.g_xnor, ifp3.g_xor, ifp3.g_nor, ifp3.g_nand, ifp3.g_or, ifp3.g_and} = gate_model(ifp3.a_out, ifp3.b_out, mode_p3);
   assign {ifw2.g_xnor, ifw2.g_xor, ifw2.g_nor, ifw2.g_nand, ifw2.g_or, ifw2.g_and} = gate_model(ifw2.a_out, ifw2.b_out, mode_w2);
   assign {ifs2.g_xnor, ifs2.g_xor, ifs2.g_nor, ifs2.g_nand, ifs2.g_or, ifs2.g_and} = gate_model(ifs2.a_out, ifs2.b_out, mode_s2);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({ifd.a_out, ifd.b_out, ifd.busy, ifd.done, ifd.pass} !== 5'b0)
         $display("[TB] FAIL reset_ctrl: got %b expected 00000", {ifd.a_out, ifd.b_out, ifd.busy, ifd.done, ifd.pass});
      if ({ifd.a_out, ifd.b_out, ifd.busy, ifd.done, ifd.pass} !== 5'b0) errors++;
      checks++;
      if (ifd.truth_table !== 24'h0) begin
         errors++;
         $display("[TB] FAIL reset_tt: got %h expected 000000", ifd.truth_table);
      end
      checks++;
      if (ifd.mismatch_cnt !== 8'd0) begin
         errors++;
         $display("[TB] FAIL reset_cnt: got %0d expected 0", ifd.mismatch_cnt);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_ideal();
      int cyc;
      mode_d = 0;
      ifd.start = 1'b1;
      @(negedge clk);
      ifd.start = 1'b0;
      checks++;
      if ({ifd.busy, ifd.a_out, ifd.b_out, ifd.pass} !== 4'b1000) begin
         errors++;
         $display("[TB] FAIL ideal_first_cycle: got %b expected 1000", {ifd.busy, ifd.a_out, ifd.b_out, ifd.pass});
      end
      cyc = 0;
      while (ifd.done !== 1'b1 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (cyc !== 9) begin
         errors++;
         $display("[TB] FAIL ideal_latency: got %0d expected 9", cyc);
      end
      checks++;
      if (ifd.truth_table !== 24'h8D65AC) begin
         errors++;
         $display("[TB] FAIL ideal_tt: got %h expected 8d65ac", ifd.truth_table);
      end
      checks++;
      if ({ifd.mismatch_cnt, ifd.pass, ifd.busy} !== {8'd0, 1'b1, 1'b0}) begin
         errors++;
         $display("[TB] FAIL ideal_status: got cnt=%0d pass=%b busy=%b expected cnt=0 pass=1 busy=0",
                  ifd.mismatch_cnt, ifd.pass, ifd.busy);
      end
      @(negedge clk);
      checks++;
      if ({ifd.done, ifd.pass, ifd.truth_table} !== {1'b0, 1'b1, 24'h8D65AC}) begin
         errors++;
         $display("[TB] FAIL ideal_after_done: got done=%b pass=%b tt=%h expected done=0 pass=1 tt=8d65ac",
                  ifd.done, ifd.pass, ifd.truth_table);
      end
   endtask

   task automatic test_and_stuck();
      int cyc;
      mode_d = 1;
      ifd.start = 1'b1;
      @(negedge clk);
      ifd.start = 1'b0;
      checks++;
      if (ifd.pass !== 1'b0) begin
         errors++;
         $display("[TB] FAIL and_pass_cleared: got %b expected 0", ifd.pass);
      end
      cyc = 0;
      while (ifd.done !== 1'b1 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (ifd.truth_table !== 24'h8965AC) begin
         errors++;
         $display("[TB] FAIL and_tt: got %h expected 8965ac", ifd.truth_table);
      end
      checks++;
      if ({ifd.mismatch_cnt, ifd.pass, ifd.done} !== {8'd1, 1'b0, 1'b1}) begin
         errors++;
         $display("[TB] FAIL and_status: got cnt=%0d pass=%b done=%b expected cnt=1 pass=0 done=1",
                  ifd.mismatch_cnt, ifd.pass, ifd.done);
      end
      mode_d = 0;
      @(negedge clk);
   endtask

   task automatic test_xor_inverted();
      int cyc;
      mode_p3 = 2;
      ifp3.start = 1'b1;
      @(negedge clk);
      ifp3.start = 1'b0;
      cyc = 0;
      while (ifp3.done !== 1'b1 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (cyc !== 25) begin
         errors++;
         $display("[TB] FAIL xor_latency: got %0d expected 25", cyc);
      end
      checks++;
      if ({ifp3.mismatch_cnt, ifp3.pass} !== {8'd12, 1'b0}) begin
         errors++;
         $display("[TB] FAIL xor_status: got cnt=%0d pass=%b expected cnt=12 pass=0", ifp3.mismatch_cnt, ifp3.pass);
      end
      checks++;
      if (ifp3.truth_table !== 24'hCC61BC) begin
         errors++;
         $display("[TB] FAIL xor_tt: got %h expected cc61bc", ifp3.truth_table);
      end
      @(negedge clk);
   endtask

   task automatic test_saturation();
      int cyc;
      mode_w2 = 3;
      ifw2.start = 1'b1;
      @(negedge clk);
      ifw2.start = 1'b0;
      cyc = 0;
      while (ifw2.done !== 1'b1 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if ({ifw2.mismatch_cnt, ifw2.pass} !== {2'd3, 1'b0}) begin
         errors++;
         $display("[TB] FAIL sat_status: got cnt=%0d pass=%b expected cnt=3 pass=0", ifw2.mismatch_cnt, ifw2.pass);
      end
      checks++;
      if (ifw2.truth_table !== 24'h0) begin
         errors++;
         $display("[TB] FAIL sat_tt: got %h expected 000000", ifw2.truth_table);
      end
      @(negedge clk);
   endtask

   // Vector stepping with a stray start mid-run and another while in DONE.
   task automatic test_settle2();
      logic [1:0] expv;
      mode_s2 = 0;
      ifs2.start = 1'b1;
      @(negedge clk);
      ifs2.start = 1'b0;
      for (int c = 0; c < 12; c++) begin
         expv = 2'(c / 3);
         checks++;
         if ({ifs2.a_out, ifs2.b_out} !== expv) begin
            errors++;
            $display("[TB] FAIL settle2_vec[%0d]: got %b expected %b", c, {ifs2.a_out, ifs2.b_out}, expv);
         end
         ifs2.start = (c == 5);
         @(negedge clk);
      end
      checks++;
      if ({ifs2.done, ifs2.busy} !== 2'b01) begin
         errors++;
         $display("[TB] FAIL settle2_pre_done: got done/busy=%b expected 01", {ifs2.done, ifs2.busy});
      end
      ifs2.start = 1'b1;
      @(negedge clk);
      ifs2.start = 1'b0;
      checks++;
      if ({ifs2.done, ifs2.busy, ifs2.pass, ifs2.truth_table} !== {1'b1, 1'b0, 1'b1, 24'h8D65AC}) begin
         errors++;
         $display("[TB] FAIL settle2_done: got done=%b busy=%b pass=%b tt=%h expected 1 0 1 8d65ac",
                  ifs2.done, ifs2.busy, ifs2.pass, ifs2.truth_table);
      end
      @(negedge clk);
      checks++;
      if ({ifs2.done, ifs2.busy} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL settle2_start_in_done: got done/busy=%b expected 00", {ifs2.done, ifs2.busy});
      end
   endtask

   task automatic test_reset_mid_run();
      int cyc;
      mode_d = 0;
      ifd.start = 1'b1;
      @(negedge clk);
      ifd.start = 1'b0;
      cyc = 0;
      while ({ifd.a_out, ifd.b_out} !== 2'b10 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (cyc !== 4) begin
         errors++;
         $display("[TB] FAIL midrst_reach_v2: got %0d expected 4", cyc);
      end
      rst = 1'b1;
      ifd.start = 1'b1;
      @(negedge clk);
      checks++;
      if ({ifd.a_out, ifd.b_out, ifd.busy, ifd.done, ifd.pass, ifd.mismatch_cnt, ifd.truth_table} !== 37'd0) begin
         errors++;
         $display("[TB] FAIL midrst_outputs: got ab=%b busy=%b done=%b pass=%b cnt=%0d tt=%h expected all 0",
                  {ifd.a_out, ifd.b_out}, ifd.busy, ifd.done, ifd.pass, ifd.mismatch_cnt, ifd.truth_table);
      end
      @(negedge clk);
      checks++;
      if (ifd.busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midrst_rst_beats_start: got busy=%b expected 0", ifd.busy);
      end
      rst = 1'b0;
      ifd.start = 1'b0;
      @(negedge clk);
      ifd.start = 1'b1;
      @(negedge clk);
      ifd.start = 1'b0;
      cyc = 0;
      while (ifd.done !== 1'b1 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if ({cyc, ifd.truth_table, ifd.mismatch_cnt, ifd.pass} !== {32'd9, 24'h8D65AC, 8'd0, 1'b1}) begin
         errors++;
         $display("[TB] FAIL midrst_rerun: got lat=%0d tt=%h cnt=%0d pass=%b expected 9 8d65ac 0 1",
                  cyc, ifd.truth_table, ifd.mismatch_cnt, ifd.pass);
      end
   endtask

   initial begin
      errors     = 0;
      checks     = 0;
      mode_d     = 0;
      mode_p3    = 2;
      mode_w2    = 3;
      mode_s2    = 0;
      rst        = 1'b1;
      ifd.start  = 1'b0;
      ifp3.start = 1'b0;
      ifw2.start = 1'b0;
      ifs2.start = 1'b0;
      test_reset();
      test_ideal();
      test_and_stuck();
      test_xor_inverted();
      test_saturation();
      test_settle2();
      test_reset_mid_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
